ex_mem_latch_gen: RTL and testbench

Parametrised EX/MEM pipeline latch, the successor to the fixed EX/MEM register. Adds:
- stall, flush and valid-bit bubble handling;
- a data-memory request FSM that holds the stage until dhit;
- a captured load-data register;
- sticky halt;
- a forwarding tap for the hazard unit.

It sits between the execute stage and the memory/writeback logic of the pipelined datapath.

---
 rtl/ex_mem_latch_gen.sv | 151 +++++++++++++++
 tb/tb_ex_mem_latch_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_latch_gen.sv
// EX/MEM pipeline latch with stall/flush bubbles, a data-memory request FSM,
// captured load data, sticky halt and a forwarding tap for the hazard unit.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no data access pending
//   PENDING | dmemREN/dmemWEN asserted, stage frozen until dhit
//   DONE    | access complete, requests low, load data valid
module ex_mem_latch_gen #(
    parameter int PAY_W  = 64,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WSEL_W = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload_in,
    input  logic              stall_in,
    input  logic              flush,
    input  logic [PAY_W-1:0]  payload_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] dstore_in,
    input  logic              dren_in,
    input  logic              dwen_in,
    input  logic              regwr_in,
    input  logic [WSEL_W-1:0] wsel_in,
    input  logic              halt_in,
    output logic [PAY_W-1:0]  payload_out,
    output logic [DATA_W-1:0] result_out,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [DATA_W-1:0] dload_out,
    output logic              regwr_out,
    output logic [WSEL_W-1:0] wsel_out,
    output logic              halt_out,
    output logic              valid_out,
    output logic              mem_busy,
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic advance;
    logic capture;
    logic bubble;
    logic dren_q;
    logic dwen_q;
    logic mem_op_in;

    assign advance   = ihit & ~stall_in & (state != PENDING);
    assign capture   = advance & ~flush;
    assign bubble    = advance & flush;
    assign mem_op_in = dren_in | dwen_in;

    // state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (advance) begin
                    state_nxt = (!flush && mem_op_in) ? PENDING : IDLE;
                end
            end
            PENDING: begin
                if (dhit) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output logic
    always_comb begin
        mem_busy  = (state == PENDING);
        dmemREN   = (state == PENDING) & dren_q;
        dmemWEN   = (state == PENDING) & dwen_q;
        fwd_valid = valid_out & regwr_out & (wsel_out != '0)
                    & ~(dren_q & (state != DONE));
        fwd_data  = dren_q ? dload_out : result_out;
    end

    assign dmemaddr = result_out[ADDR_W-1:0];

    // pipeline payload; a flushed advance loads a bubble, halt stays sticky
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            payload_out <= '0;
            result_out  <= '0;
            dmemstore   <= '0;
            dren_q      <= 1'b0;
            dwen_q      <= 1'b0;
            regwr_out   <= 1'b0;
            wsel_out    <= '0;
            valid_out   <= 1'b0;
            halt_out    <= 1'b0;
        end else if (capture) begin
            payload_out <= payload_in;
            result_out  <= result_in;
            dmemstore   <= dstore_in;
            dren_q      <= dren_in;
            // a load+store combination is resolved as a load
            dwen_q      <= dwen_in & ~dren_in;
            regwr_out   <= regwr_in;
            wsel_out    <= wsel_in;
            valid_out   <= 1'b1;
            halt_out    <= halt_out | halt_in;
        end else if (bubble) begin
            payload_out <= '0;
            result_out  <= '0;
            dmemstore   <= '0;
            dren_q      <= 1'b0;
            dwen_q      <= 1'b0;
            regwr_out   <= 1'b0;
            wsel_out    <= '0;
            valid_out   <= 1'b0;
        end
    end

    // load data is captured only when the access in flight is a load
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dload_out <= '0;
        end else if (bubble) begin
            dload_out <= '0;
        end else if ((state == PENDING) && dhit && dren_q) begin
            dload_out <= dmemload_in;
        end
    end

endmodule

// File: tb/tb_ex_mem_latch_gen.sv
// Directed bench for ex_mem_latch_gen: a vector table stepped one clock per
// row, plus a hand sequence for asynchronous reset during an outstanding load.
module tb_ex_mem_latch_gen;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, stall_in, flush;
    logic [31:0] dmemload_in;
    logic [63:0] payload_in;
    logic [31:0] result_in, dstore_in;
    logic        dren_in, dwen_in, regwr_in, halt_in;
    logic [4:0]  wsel_in;
    logic [63:0] payload_out;
    logic [31:0] result_out, dmemaddr, dmemstore, dload_out, fwd_data;
    logic        dmemREN, dmemWEN, regwr_out, halt_out, valid_out, mem_busy, fwd_valid;
    logic [4:0]  wsel_out;

    int checks = 0;
    int errors = 0;

    ex_mem_latch_gen dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemload_in(dmemload_in),
        .stall_in(stall_in), .flush(flush), .payload_in(payload_in),
        .result_in(result_in), .dstore_in(dstore_in), .dren_in(dren_in),
        .dwen_in(dwen_in), .regwr_in(regwr_in), .wsel_in(wsel_in), .halt_in(halt_in),
        .payload_out(payload_out), .result_out(result_out), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dload_out(dload_out), .regwr_out(regwr_out), .wsel_out(wsel_out),
        .halt_out(halt_out), .valid_out(valid_out), .mem_busy(mem_busy),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        n_rst, ihit, dhit, stall, flush, dren, dwen, regwr, halt;
        logic [4:0]  wsel;
        logic [31:0] result, dstore, dld;
        logic        e_valid, e_regwr, e_ren, e_wen, e_busy, e_halt, e_fwdv;
        logic [31:0] e_result, e_store, e_dload, e_fwdd;
    } vec_t;

    vec_t v [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        nRST        = x.n_rst;
        ihit        = x.ihit;
        dhit        = x.dhit;
        stall_in    = x.stall;
        flush       = x.flush;
        dren_in     = x.dren;
        dwen_in     = x.dwen;
        regwr_in    = x.regwr;
        halt_in     = x.halt;
        wsel_in     = x.wsel;
        result_in   = x.result;
        dstore_in   = x.dstore;
        dmemload_in = x.dld;
        payload_in  = {x.result, ~x.result};
        assert (!(dren_in && dwen_in)) else $error("dren_in and dwen_in both set");
    endtask

    initial begin
        //          rst ih dh st fl rd wr rw ht ws  result         dstore   dload
        //          val rw ren wen busy halt fwdv  result  store  dload  fwdd
        v[0]  = '{0,0,0,0,0,0,0,0,0,0, 32'h0,   32'h0, 32'h0,
                  0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[1]  = '{1,1,0,0,0,0,0,1,0,3, 32'h10,  32'h0, 32'h0,
                  1,1,0,0,0,0,1, 32'h10, 32'h0, 32'h0, 32'h10};
        v[2]  = '{1,1,0,0,0,1,0,1,0,5, 32'h100, 32'h0, 32'h0,
                  1,1,1,0,1,0,0, 32'h100, 32'h0, 32'h0, 32'h0};
        v[3]  = '{1,1,0,0,0,0,0,1,0,9, 32'h999, 32'h0, 32'h0,
                  1,1,1,0,1,0,0, 32'h100, 32'h0, 32'h0, 32'h0};
        v[4]  = '{1,1,0,0,0,0,0,0,0,0, 32'h0,   32'h0, 32'h0,
                  1,1,1,0,1,0,0, 32'h100, 32'h0, 32'h0, 32'h0};
        v[5]  = '{1,0,1,0,0,0,0,0,0,0, 32'h0,   32'h0, 32'hDEADBEEF,
                  1,1,0,0,0,0,1, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
        v[6]  = '{1,1,0,1,0,0,0,1,0,4, 32'h55,  32'h0, 32'h0,
                  1,1,0,0,0,0,1, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
        v[7]  = '{1,0,0,0,1,0,0,1,0,4, 32'h55,  32'h0, 32'h0,
                  1,1,0,0,0,0,1, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
        v[8]  = '{1,1,0,0,0,0,1,0,0,0, 32'h200, 32'h1234, 32'h0,
                  1,0,0,1,1,0,0, 32'h200, 32'h1234, 32'hDEADBEEF, 32'h200};
        v[9]  = '{1,1,1,0,0,0,0,1,0,6, 32'h66,  32'h0, 32'hFFFFFFFF,
                  1,0,0,0,0,0,0, 32'h200, 32'h1234, 32'hDEADBEEF, 32'h200};
        v[10] = '{1,1,0,0,0,0,0,1,0,7, 32'h20,  32'h0, 32'h0,
                  1,1,0,0,0,0,1, 32'h20, 32'h0, 32'hDEADBEEF, 32'h20};
        v[11] = '{1,1,0,0,1,1,0,1,1,7, 32'h77,  32'h5, 32'h0,
                  0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[12] = '{1,0,1,0,0,0,0,0,0,0, 32'h0,   32'h0, 32'h1111,
                  0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[13] = '{1,1,0,0,0,0,0,1,1,0, 32'h30,  32'h0, 32'h0,
                  1,1,0,0,0,1,0, 32'h30, 32'h0, 32'h0, 32'h30};
        v[14] = '{1,1,0,0,0,0,0,1,0,2, 32'h40,  32'h0, 32'h0,
                  1,1,0,0,0,1,1, 32'h40, 32'h0, 32'h0, 32'h40};
        v[15] = '{1,1,0,0,1,0,0,0,0,0, 32'h0,   32'h0, 32'h0,
                  0,0,0,0,0,1,0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[16] = '{0,0,0,0,0,0,0,0,0,0, 32'h0,   32'h0, 32'h0,
                  0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0};

        for (int i = 0; i < 17; i++) begin
            @(negedge CLK);
            drive(v[i]);
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("r%0d valid_out", i), 64'(valid_out), 64'(v[i].e_valid));
            chk($sformatf("r%0d regwr_out", i), 64'(regwr_out), 64'(v[i].e_regwr));
            chk($sformatf("r%0d dmemREN", i),   64'(dmemREN),   64'(v[i].e_ren));
            chk($sformatf("r%0d dmemWEN", i),   64'(dmemWEN),   64'(v[i].e_wen));
            chk($sformatf("r%0d mem_busy", i),  64'(mem_busy),  64'(v[i].e_busy));
            chk($sformatf("r%0d halt_out", i),  64'(halt_out),  64'(v[i].e_halt));
            chk($sformatf("r%0d fwd_valid", i), 64'(fwd_valid), 64'(v[i].e_fwdv));
            chk($sformatf("r%0d result_out", i), 64'(result_out), 64'(v[i].e_result));
            chk($sformatf("r%0d dmemaddr", i),  64'(dmemaddr),  64'(v[i].e_result));
            chk($sformatf("r%0d dmemstore", i), 64'(dmemstore), 64'(v[i].e_store));
            chk($sformatf("r%0d dload_out", i), 64'(dload_out), 64'(v[i].e_dload));
            chk($sformatf("r%0d fwd_data", i),  64'(fwd_data),  64'(v[i].e_fwdd));
            if (v[i].e_valid)
                chk($sformatf("r%0d payload_out", i), payload_out,
                    {v[i].e_result, ~v[i].e_result});
        end

        // asynchronous reset while a load is outstanding
        @(negedge CLK);
        drive('{1,1,0,0,0,1,0,1,0,8, 32'h300, 32'h0, 32'h0,
                0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0});
        @(posedge CLK);
        #1;
        chk("rst_mid dmemREN before", 64'(dmemREN), 64'd1);
        chk("rst_mid mem_busy before", 64'(mem_busy), 64'd1);
        #1 nRST = 1'b0;
        ihit = 1'b0;
        dren_in = 1'b0;
        #1;
        chk("rst_mid dmemREN after", 64'(dmemREN), 64'd0);
        chk("rst_mid mem_busy after", 64'(mem_busy), 64'd0);
        chk("rst_mid valid_out after", 64'(valid_out), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        dhit = 1'b1;
        dmemload_in = 32'hABCD_0123;
        @(posedge CLK);
        @(negedge CLK);
        dhit = 1'b0;
        chk("rst_mid late dhit dload_out", 64'(dload_out), 64'd0);
        chk("rst_mid late dhit dmemREN", 64'(dmemREN), 64'd0);
        chk("rst_mid late dhit mem_busy", 64'(mem_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
